// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared defaults and segment-count derivation for adder_pipe
package adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Guards against divide-by-zero so a bad SEG reaches the elaboration check.
  function automatic int nseg_of(input int width, input int seg);
    return (seg < 1) ? 1 : width / seg;
  endfunction
endpackage

// File: rtl/adder_seg.sv
// rtl/adder_seg.sv - combinational SEG-bit ripple adder segment
module adder_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end

  assign co = c[SEG];
endmodule

// File: rtl/fa.sv
// rtl/fa.sv - full adder cell built from two half adders
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/ha.sv
// rtl/ha.sv - half adder cell
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - segmented carry-pipelined adder with ready/valid flow control
// Define ADDER_PIPE_SAT_EN to saturate sum on carry-out and add the sat port.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER_PIPE_SAT_EN
  output logic             sat,
`endif
  output logic             cout
);
  localparam int NSEG = nseg_of(WIDTH, SEG);

  if ((SEG < 1) ? 1'b1 : ((WIDTH < SEG) || (WIDTH % SEG != 0))) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a positive multiple of SEG, SEG >= 1");
  end

  // Stage k holds operands (upper segments still pending), partial sum and carry.
  logic             v_q [NSEG];
  logic             c_q [NSEG];
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];

  logic [SEG-1:0]   seg_s  [NSEG];
  logic             seg_co [NSEG];
  logic             advance;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      adder_seg #(.SEG(SEG)) u_seg (
        .a (a[SEG-1:0]),
        .b (b[SEG-1:0]),
        .ci(cin),
        .s (seg_s[k]),
        .co(seg_co[k])
      );
    end else begin : g_rest
      adder_seg #(.SEG(SEG)) u_seg (
        .a (a_q[k-1][k*SEG +: SEG]),
        .b (b_q[k-1][k*SEG +: SEG]),
        .ci(c_q[k-1]),
        .s (seg_s[k]),
        .co(seg_co[k])
      );
    end
  end

  // A held result blocks every stage, so nothing can overtake or be dropped.
  assign advance  = !(v_q[NSEG-1] && !out_ready);
  assign in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0] <= a;
        b_q[0] <= b;
        s_q[0] <= WIDTH'(seg_s[0]);
        c_q[0] <= seg_co[0];
      end
      for (int k = 1; k < NSEG; k++) begin
        v_q[k]                 <= v_q[k-1];
        a_q[k]                 <= a_q[k-1];
        b_q[k]                 <= b_q[k-1];
        s_q[k]                 <= s_q[k-1];
        s_q[k][k*SEG +: SEG]   <= seg_s[k];
        c_q[k]                 <= seg_co[k];
      end
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign cout      = c_q[NSEG-1];

`ifdef ADDER_PIPE_SAT_EN
  assign sat = c_q[NSEG-1];
  assign sum = c_q[NSEG-1] ? '1 : s_q[NSEG-1];
`else
  assign sum = s_q[NSEG-1];
`endif
endmodule
